// File: rtl/residual_fork.sv
`default_nettype none
// ============================================================================
// Module   : residual_fork
// Brief    : Splits a pixel stream at the input of a residual block. Channel 1
//            is a one-cycle registered copy. Channel 2 is a shortcut copy held
//            in a FIFO and popped by rd_req. A per-frame pixel counter pulses
//            frame_done. Optional macro RESIDUAL_FORK_ERR_EN adds sticky
//            overflow/underflow status ports.
// Revision : 1.0 - initial release
// ============================================================================
module residual_fork #(
    parameter int D          = 299,
    parameter int data_width = 32,
    parameter int FIFO_DEPTH = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [data_width-1:0] pxl_in,
    input  logic                  rd_req,
    output logic                  valid_out_1,
    output logic [data_width-1:0] pxl_out_1,
    output logic                  valid_out_2,
    output logic [data_width-1:0] pxl_out_2,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  frame_done
`ifdef RESIDUAL_FORK_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int              c_FRAME_LEN = D * D;
    localparam int              c_PIX_W     = (c_FRAME_LEN > 1) ? $clog2(c_FRAME_LEN) : 1;
    localparam logic [c_PIX_W-1:0] c_PIX_LAST = c_PIX_W'(c_FRAME_LEN - 1);
    localparam logic [c_PIX_W-1:0] c_PIX_ONE  = c_PIX_W'(1);
    localparam logic [ADDR_W:0]    c_DEPTH    = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]    c_CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0]  c_PTR_ONE  = ADDR_W'(1);

    logic [data_width-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [ADDR_W:0]       r_count;
    logic                  r_full;
    logic                  r_empty;
    logic [c_PIX_W-1:0]    r_pix_cnt;
    logic                  r_valid_out_1;
    logic [data_width-1:0] r_pxl_out_1;
    logic                  r_valid_out_2;
    logic [data_width-1:0] r_pxl_out_2;
    logic                  r_frame_done;

    logic                  w_rd_en;
    logic                  w_wr_en;
    logic [ADDR_W:0]       w_count_nxt;

    // A full FIFO still accepts a write when the same edge pops a word.
    assign w_rd_en = rd_req & ~r_empty;
    assign w_wr_en = valid_in & (~r_full | w_rd_en);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= pxl_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_pix_cnt     <= '0;
            r_valid_out_1 <= 1'b0;
            r_pxl_out_1   <= '0;
            r_valid_out_2 <= 1'b0;
            r_pxl_out_2   <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_valid_out_1 <= valid_in;
            if (valid_in) begin
                r_pxl_out_1 <= pxl_in;
            end

            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            r_valid_out_2 <= w_rd_en;
            if (w_rd_en) begin
                r_pxl_out_2 <= r_mem[r_rd_ptr];
                r_rd_ptr    <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
            r_empty <= (w_count_nxt == '0);

            r_frame_done <= valid_in && (r_pix_cnt == c_PIX_LAST);
            if (valid_in) begin
                r_pix_cnt <= (r_pix_cnt == c_PIX_LAST) ? '0 : r_pix_cnt + c_PIX_ONE;
            end
        end
    end

`ifdef RESIDUAL_FORK_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow  | (valid_in & ~w_wr_en);
            r_underflow <= r_underflow | (rd_req & r_empty);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign valid_out_1 = r_valid_out_1;
    assign pxl_out_1   = r_pxl_out_1;
    assign valid_out_2 = r_valid_out_2;
    assign pxl_out_2   = r_pxl_out_2;
    assign fifo_full   = r_full;
    assign fifo_empty  = r_empty;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_residual_fork.sv
`default_nettype none
// ============================================================================
// Module   : tb_residual_fork
// Brief    : Scoreboard bench for residual_fork (D=4, 1024-word FIFO) driven
//            by directed and random stimulus against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_residual_fork;

    localparam int c_D     = 4;
    localparam int c_T     = c_D * c_D;
    localparam int c_DEPTH = 1024;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] pxl_in;
    logic        rd_req;
    logic        valid_out_1;
    logic [31:0] pxl_out_1;
    logic        valid_out_2;
    logic [31:0] pxl_out_2;
    logic        fifo_full;
    logic        fifo_empty;
    logic        frame_done;
`ifdef RESIDUAL_FORK_ERR_EN
    logic        overflow;
    logic        underflow;
`endif

    residual_fork #(
        .D          (c_D),
        .data_width (32),
        .FIFO_DEPTH (c_DEPTH),
        .ADDR_W     (10)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .pxl_in      (pxl_in),
        .rd_req      (rd_req),
        .valid_out_1 (valid_out_1),
        .pxl_out_1   (pxl_out_1),
        .valid_out_2 (valid_out_2),
        .pxl_out_2   (pxl_out_2),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .frame_done  (frame_done)
`ifdef RESIDUAL_FORK_ERR_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        v1;
        logic        v2;
        logic        fd;
        logic        full;
        logic        empty;
        logic [31:0] p2;
        logic        ov;
        logic        un;
    } rec_t;

    rec_t        rec_q[$];
    logic [31:0] ch1_q[$];
    logic [31:0] ch2_q[$];
    logic [31:0] m_fifo[$];
    int          m_pix;
    logic [31:0] m_last2;
    logic        m_ov;
    logic        m_un;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, frame position as an integer modulo T.
    always @(posedge clk) begin
        rec_t r;
        logic was_empty;
        if (!reset) begin
            m_fifo.delete();
            m_pix   = 0;
            m_last2 = '0;
            m_ov    = 1'b0;
            m_un    = 1'b0;
            r = '{rst: 1'b1, v1: 1'b0, v2: 1'b0, fd: 1'b0, full: 1'b0,
                  empty: 1'b1, p2: 32'h0, ov: 1'b0, un: 1'b0};
        end else begin
            r.rst     = 1'b0;
            r.v1      = valid_in;
            r.v2      = 1'b0;
            was_empty = (m_fifo.size() == 0);
            if (valid_in) ch1_q.push_back(pxl_in);
            if (rd_req) begin
                if (!was_empty) begin
                    m_last2 = m_fifo.pop_front();
                    ch2_q.push_back(m_last2);
                    r.v2 = 1'b1;
                end else begin
                    m_un = 1'b1;
                end
            end
            if (valid_in) begin
                if (m_fifo.size() < c_DEPTH) m_fifo.push_back(pxl_in);
                else m_ov = 1'b1;
            end
            r.fd = valid_in && (m_pix == c_T - 1);
            if (valid_in) m_pix = (m_pix + 1) % c_T;
            r.full  = (m_fifo.size() == c_DEPTH);
            r.empty = (m_fifo.size() == 0);
            r.p2    = m_last2;
            r.ov    = m_ov;
            r.un    = m_un;
        end
        rec_q.push_back(r);
    end

    // Monitor: compares DUT outputs against the oldest expected response.
    always @(negedge clk) begin
        rec_t        cr;
        logic [31:0] e;
        if (rec_q.size() > 0) begin
            cr = rec_q.pop_front();
            check("valid_out_1", {31'b0, valid_out_1}, {31'b0, cr.v1});
            check("valid_out_2", {31'b0, valid_out_2}, {31'b0, cr.v2});
            check("frame_done", {31'b0, frame_done}, {31'b0, cr.fd});
            check("fifo_full", {31'b0, fifo_full}, {31'b0, cr.full});
            check("fifo_empty", {31'b0, fifo_empty}, {31'b0, cr.empty});
            check("pxl_out_2_hold", pxl_out_2, cr.p2);
            if (cr.rst) check("pxl_out_1_rst", pxl_out_1, 32'h0);
`ifdef RESIDUAL_FORK_ERR_EN
            check("overflow", {31'b0, overflow}, {31'b0, cr.ov});
            check("underflow", {31'b0, underflow}, {31'b0, cr.un});
`endif
        end
        if (valid_out_1) begin
            if (ch1_q.size() == 0) check("ch1_unexpected", 32'h1, 32'h0);
            else begin
                e = ch1_q.pop_front();
                check("pxl_out_1", pxl_out_1, e);
            end
        end
        if (valid_out_2) begin
            if (ch2_q.size() == 0) check("ch2_unexpected", 32'h1, 32'h0);
            else begin
                e = ch2_q.pop_front();
                check("pxl_out_2", pxl_out_2, e);
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        @(negedge clk);
        #1;
        valid_in = v;
        pxl_in   = d;
        rd_req   = r;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            valid_in = 1'($urandom_range(0, 1));
            pxl_in   = $urandom;
            rd_req   = 1'($urandom_range(0, 1));
        end
        valid_in = 1'b0;
        rd_req   = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        pxl_in   = '0;
        rd_req   = 1'b0;
        m_pix    = 0;
        m_last2  = '0;
        m_ov     = 1'b0;
        m_un     = 1'b0;

        do_reset(6);
        drive(1'b0, 32'h0, 1'b0);

        // Eight words in, then eight reads.
        for (int i = 1; i <= 8; i++) drive(1'b1, 32'(i), 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0);

        // Fill to capacity, then one dropped word.
        for (int i = 0; i < c_DEPTH; i++) drive(1'b1, $urandom, 1'b0);
        drive(1'b1, 32'hDEAD, 1'b0);
        drive(1'b0, 32'h0, 1'b0);

        // Full FIFO with simultaneous write and read.
        for (int i = 0; i < 100; i++) drive(1'b1, $urandom, 1'b1);

        // Drain past empty.
        for (int i = 0; i < c_DEPTH + 4; i++) drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0);

        // Frame counting across resets.
        do_reset(2);
        for (int i = 0; i < 40; i++) drive(1'b1, 32'h100 + 32'(i), 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 20; i++) drive(1'b1, 32'h200 + 32'(i), 1'($urandom_range(0, 1)));
        do_reset(1);
        for (int i = 0; i < 16; i++) drive(1'b1, 32'h300 + 32'(i), 1'b0);
        drive(1'b0, 32'h0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #1;
        check("ch1_drained", 32'(ch1_q.size()), 32'h0);
        check("ch2_drained", 32'(ch2_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
